// File: rtl/wb_stage_p.sv
// Writeback pipeline stage: result select, sub-word load formatting, write
// suppression, stall/flush handling and a retired-instruction counter.
module wb_stage_p #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5,
    parameter int CNTW  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wb_in_valid,
    input  logic                          wb_stall,
    input  logic                          wb_flush,
    input  logic [1:0]                    wb_src,
    input  logic [XLEN-1:0]               wb_alu_res,
    input  logic [XLEN-1:0]               wb_read_data,
    input  logic [XLEN-1:0]               wb_link_pc,
    input  logic [1:0]                    wb_ld_size,
    input  logic                          wb_ld_unsigned,
    input  logic [$clog2(XLEN/8)-1:0]     wb_ld_offset,
    input  logic [RADDR-1:0]              wb_i_write_reg,
    input  logic                          wb_i_reg_write,
    output logic [RADDR-1:0]              wb_write_reg,
    output logic [XLEN-1:0]               wb_write_data,
    output logic                          wb_reg_write,
    output logic                          wb_valid,
    output logic                          wb_misalign,
    output logic [CNTW-1:0]               wb_retired_cnt
);

    localparam int OFFW = $clog2(XLEN / 8);
    localparam int PADW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'b00,
        SRC_MEM  = 2'b01,
        SRC_LINK = 2'b10,
        SRC_RSVD = 2'b11
    } src_e;

    logic [1:0]      effSize;
    logic [OFFW-1:0] alignedOff;
    logic [PADW-1:0] padBits;
    logic            loadMis;
    logic            misalign;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] padded;
    logic [XLEN-1:0] loadVal;
    logic [XLEN-1:0] selData;
    logic            doRetire;

    // A misaligned lane is still formatted from the naturally aligned lane below it.
    always_comb begin
        effSize    = (XLEN == 32 && wb_ld_size == 2'b11) ? 2'b10 : wb_ld_size;
        alignedOff = wb_ld_offset;
        padBits    = PADW'(XLEN - 8);
        loadMis    = 1'b0;
        case (effSize)
            2'b01: begin
                alignedOff = wb_ld_offset & ~OFFW'(1);
                padBits    = PADW'(XLEN - 16);
                loadMis    = wb_ld_offset[0];
            end
            2'b10: begin
                alignedOff = wb_ld_offset & ~OFFW'(3);
                padBits    = PADW'(XLEN - 32);
                loadMis    = (wb_ld_offset[1:0] != 2'b00);
            end
            2'b11: begin
                alignedOff = '0;
                padBits    = '0;
                loadMis    = (wb_ld_offset != '0);
            end
            default: ;
        endcase
    end

    // Extension: push the lane to the top, then shift back logically or arithmetically.
    always_comb begin
        shifted = wb_read_data >> {alignedOff, 3'b000};
        padded  = shifted << padBits;
        if (wb_ld_unsigned)
            loadVal = padded >> padBits;
        else
            loadVal = $signed(padded) >>> padBits;
    end

    always_comb begin
        misalign = 1'b0;
        selData  = wb_alu_res;
        case (src_e'(wb_src))
            SRC_MEM: begin
                selData  = loadVal;
                misalign = loadMis;
            end
            SRC_LINK: selData = wb_link_pc;
            default:  selData = wb_alu_res;
        endcase
        doRetire = wb_in_valid & ~misalign;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid       <= 1'b0;
            wb_write_reg   <= '0;
            wb_write_data  <= '0;
            wb_reg_write   <= 1'b0;
            wb_misalign    <= 1'b0;
            wb_retired_cnt <= '0;
        end else if (wb_flush) begin
            wb_valid      <= 1'b0;
            wb_write_reg  <= '0;
            wb_write_data <= '0;
            wb_reg_write  <= 1'b0;
            wb_misalign   <= 1'b0;
        end else if (!wb_stall) begin
            wb_valid      <= wb_in_valid;
            wb_write_reg  <= wb_i_write_reg;
            wb_write_data <= selData;
            wb_reg_write  <= wb_in_valid & wb_i_reg_write & (wb_i_write_reg != '0) & ~misalign;
            wb_misalign   <= wb_in_valid & misalign;
            if (doRetire)
                wb_retired_cnt <= wb_retired_cnt + 1'b1;
        end
    end

endmodule
